vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator with registered sync outputs, programmable sync polarity, a frame-synchronous pixel-request port that leads the display by a fixed lookahead, and frame/line start strobes. It sits between the pixel-clock source and the framebuffer/pixel pipeline. It drives the DAC sync/blank pins and tells upstream logic which pixel to fetch `LOOKAHEAD` cycles before it is displayed.

## Interface
- `CW`, 11: width of internal and output counters; all totals must fit in `CW` bits.
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal segment lengths in pixels.
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical segment lengths in lines.
- `H_POL`, 0 / `V_POL`, 0: sync active level; 0 = active low.
- `LOOKAHEAD`, 2: cycles from request to display, range 0..7.
- `FCW`, 8: frame counter width.
- `vgaclk` in 1: pixel clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: count enable; 0 freezes the whole block.
- `hsync` out 1, `vsync` out 1: registered syncs, polarity per `H_POL`/`V_POL`.
- `vga_sync` out 1: `hsync & vsync`.
- `vga_blank` out 1: 1 = visible pixel (DAC blank_n convention).
- `counter_H` out CW, `counter_V` out CW: display-aligned raster position.
- `frame_start` out 1: one-cycle pulse when the display position is (0,0).
- `line_start` out 1: one-cycle pulse when `counter_H` = 0.
- `req_valid` out 1, `req_x` out CW, `req_y` out CW: pixel request for an active position.
- `frame_cnt` out FCW: completed-frame count; wraps modulo 2^FCW.

## Operation
- `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP` (800). `V_TOTAL` = sum of the V segments (525).
- The internal position (h,v) advances one pixel per enabled cycle.
- h counts 0..`H_TOTAL`-1. At `H_TOTAL`-1, h goes to 0 and v increments. At (`H_TOTAL`-1, `V_TOTAL`-1), both go to 0 and `frame_cnt` increments.
- Each axis has a phase FSM: ACTIVE → FP → SYNC → BP → ACTIVE. Transitions occur when the segment-local counter reaches its length-1. The FSM is authoritative for sync/blank; no range comparators on h/v.
- The V FSM advances only on the horizontal wrap cycle.
- Request stage, registered from (h,v):
  - `req_valid` = (H phase ACTIVE && V phase ACTIVE).
  - `req_x` = h, `req_y` = v.
  - `req_x`/`req_y` update every cycle, valid or not.
- Display stage: request-stage values pass through a `LOOKAHEAD`-deep delay line. This produces `counter_H`, `counter_V`, `vga_blank` (= delayed `req_valid`) and the phase-derived syncs.
- `frame_start` and `line_start` are decoded on the display side.
- `en`=0: counters, FSMs, delay line and all outputs hold their values; no pulse is repeated.
- Invalid parameters fail elaboration: any segment length 0, a total ≥ 2^`CW`, or `LOOKAHEAD` > 7.

## Timing
- Reset (asynchronous assert, synchronous-to-`vgaclk` release):
  - (h,v) = (0,0); both FSMs in ACTIVE.
  - Every delay-line stage and every output holds the blanked/idle value: `req_valid`=0, `vga_blank`=0, `hsync`=!`H_POL`, `vsync`=!`V_POL`, counters 0, `frame_start`=0, `line_start`=0, `frame_cnt`=0.
- First enabled edge after release: request stage shows (0,0) with `req_valid`=1. The display shows (0,0) with `vga_blank`=1 and `frame_start`=1 exactly `LOOKAHEAD` enabled cycles later.
- With `LOOKAHEAD`=0, request and display outputs are identical in the same cycle.
- `hsync` is asserted for exactly `H_SYNC` cycles, starting at `counter_H` = `H_ACTIVE`+`H_FP`.
- `vsync` is asserted for exactly `V_SYNC` whole lines; it changes on the same cycle `counter_H` becomes 0.
- Reset mid-frame: all outputs return to reset values immediately. No partial pulse is emitted after release other than the normal (0,0) sequence.

## Structure
- Package `vga_pkg` holds:
  - `phase_e` {ACTIVE, FP, SYNC, BP};
  - a `vga_timing_t` struct with the eight segment lengths;
  - constant `VGA_640x480` with the defaults above;
  - helper functions `h_total()` / `v_total()`.
- Sub-module `vga_delay_line`: a parametrised-width, parametrised-depth register chain with enable and async active-low reset to a parameter value. Depth 0 is a pass-through.

## Test plan
- Reset held, then released with `en`=1 → all outputs at reset values. After 2 cycles: `counter_H`=0, `counter_V`=0, `vga_blank`=1, `frame_start`=1.
- Free-run 2 frames (defaults) → `frame_start` pulses exactly 420000 cycles apart; `line_start` every 800 cycles; `frame_cnt` 0→1→2.
- Within one line → `hsync`=0 for 96 cycles, beginning at `counter_H`=656; `vga_blank`=1 for exactly `counter_H` 0..639.
- Request at `req_x`=100, `req_y`=7 in cycle T → `counter_H`=100, `counter_V`=7, `vga_blank`=1 at T+2. Repeat with `LOOKAHEAD`=0 → same cycle.
- `en`=0 for 37 cycles mid-line at `counter_H`=300 → all outputs frozen. Resumes at 301 and the frame period extends by 37.
- Reduced config (H 8/2/3/2, V 4/1/2/1, `H_POL`=1, `FCW`=2) → `hsync` high for counter_H 10..12; `vsync` high for lines 5..6; `frame_cnt` wraps 3→0. Then `rst_n` pulsed at (5,2) → immediate reset values.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing types, the 640x480@60 default mode and total-length helpers.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } phase_e;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    function automatic int unsigned h_total(input vga_timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int unsigned v_total(input vga_timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

    // Segment order within a line or a frame.
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            ACTIVE:  return FP;
            FP:      return SYNC;
            SYNC:    return BP;
            default: return ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled register chain with asynchronous reset to a fixed value; depth 0 is a wire.
module vga_delay_line #(
    parameter int unsigned W       = 1,
    parameter int unsigned DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (DEPTH == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = &{1'b0, i_clk, i_rst_n, i_en};
        assign o_q      = i_d;
    end else begin : g_chain
        logic [W-1:0] r_stage [DEPTH];

        // shift one stage per enabled cycle; reset loads the idle value everywhere
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
            end else if (i_en) begin
                r_stage[0] <= i_d;
                for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: phase FSMs per axis drive a registered request
// stage, which a LOOKAHEAD-deep delay line turns into display-aligned outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CW        = 11,
    parameter int unsigned H_ACTIVE  = VGA_640x480.h_active,
    parameter int unsigned H_FP      = VGA_640x480.h_fp,
    parameter int unsigned H_SYNC    = VGA_640x480.h_sync,
    parameter int unsigned H_BP      = VGA_640x480.h_bp,
    parameter int unsigned V_ACTIVE  = VGA_640x480.v_active,
    parameter int unsigned V_FP      = VGA_640x480.v_fp,
    parameter int unsigned V_SYNC    = VGA_640x480.v_sync,
    parameter int unsigned V_BP      = VGA_640x480.v_bp,
    parameter bit          H_POL     = 1'b0,
    parameter bit          V_POL     = 1'b0,
    parameter int unsigned LOOKAHEAD = 2,
    parameter int unsigned FCW       = 8
) (
    input  logic           vgaclk,
    input  logic           rst_n,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           vga_sync,
    output logic           vga_blank,
    output logic [CW-1:0]  counter_H,
    output logic [CW-1:0]  counter_V,
    output logic           frame_start,
    output logic           line_start,
    output logic           req_valid,
    output logic [CW-1:0]  req_x,
    output logic [CW-1:0]  req_y,
    output logic [FCW-1:0] frame_cnt
);

    localparam vga_timing_t TIM = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    };
    localparam int unsigned H_TOTAL = h_total(TIM);
    localparam int unsigned V_TOTAL = v_total(TIM);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // pipeline bundle: {live, valid, hsync, vsync, x, y}
    localparam int unsigned PW = 2 * CW + 4;
    localparam logic [PW-1:0] PIPE_IDLE = {2'b00, ~H_POL, ~V_POL, {(2 * CW){1'b0}}};

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_segment
        $error("vga_timing_gen: every segment length must be non-zero");
    end
    if (64'(H_TOTAL) >= (64'd1 << CW) || 64'(V_TOTAL) >= (64'd1 << CW)) begin : g_bad_total
        $error("vga_timing_gen: line/frame total does not fit in CW bits");
    end
    if (LOOKAHEAD > 7) begin : g_bad_lookahead
        $error("vga_timing_gen: LOOKAHEAD must be 0..7");
    end

    phase_e         r_h_phase, w_h_phase_nxt;
    phase_e         r_v_phase, w_v_phase_nxt;
    logic [CW-1:0]  r_h_seg, w_h_seg_nxt, w_h_seg_last;
    logic [CW-1:0]  r_v_seg, w_v_seg_nxt, w_v_seg_last;
    logic [CW-1:0]  r_h, r_v, w_h_nxt, w_v_nxt;
    logic [FCW-1:0] r_frame_cnt;
    logic           w_h_wrap, w_v_wrap, w_h_seg_end, w_v_seg_end;

    logic           r_req_live, r_req_valid, r_req_hsync, r_req_vsync;
    logic [CW-1:0]  r_req_x, r_req_y;
    logic [PW-1:0]  w_req_bus, w_disp_bus;
    logic           w_disp_live;

    assign w_h_wrap    = (r_h == H_LAST);
    assign w_v_wrap    = (r_v == V_LAST);
    assign w_h_seg_end = (r_h_seg == w_h_seg_last);
    assign w_v_seg_end = (r_v_seg == w_v_seg_last);

    // last segment-local count for the current horizontal phase
    always_comb begin
        w_h_seg_last = '0;
        unique case (r_h_phase)
            ACTIVE: w_h_seg_last = CW'(H_ACTIVE - 1);
            FP:     w_h_seg_last = CW'(H_FP - 1);
            SYNC:   w_h_seg_last = CW'(H_SYNC - 1);
            BP:     w_h_seg_last = CW'(H_BP - 1);
        endcase
    end

    // last segment-local count for the current vertical phase
    always_comb begin
        w_v_seg_last = '0;
        unique case (r_v_phase)
            ACTIVE: w_v_seg_last = CW'(V_ACTIVE - 1);
            FP:     w_v_seg_last = CW'(V_FP - 1);
            SYNC:   w_v_seg_last = CW'(V_SYNC - 1);
            BP:     w_v_seg_last = CW'(V_BP - 1);
        endcase
    end

    // horizontal next phase: advance every pixel, change phase at segment end
    always_comb begin
        w_h_phase_nxt = r_h_phase;
        w_h_seg_nxt   = r_h_seg + CW'(1);
        if (w_h_seg_end) begin
            w_h_phase_nxt = next_phase(r_h_phase);
            w_h_seg_nxt   = '0;
        end
    end

    // vertical next phase: only moves on the horizontal wrap cycle
    always_comb begin
        w_v_phase_nxt = r_v_phase;
        w_v_seg_nxt   = r_v_seg;
        if (w_h_wrap) begin
            w_v_seg_nxt = r_v_seg + CW'(1);
            if (w_v_seg_end) begin
                w_v_phase_nxt = next_phase(r_v_phase);
                w_v_seg_nxt   = '0;
            end
        end
    end

    // raster position next value
    always_comb begin
        w_h_nxt = w_h_wrap ? '0 : r_h + CW'(1);
        w_v_nxt = r_v;
        if (w_h_wrap) w_v_nxt = w_v_wrap ? '0 : r_v + CW'(1);
    end

    // phase FSM state, segment counters, position and frame counter
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_phase   <= ACTIVE;
            r_v_phase   <= ACTIVE;
            r_h_seg     <= '0;
            r_v_seg     <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
        end else if (en) begin
            r_h_phase <= w_h_phase_nxt;
            r_v_phase <= w_v_phase_nxt;
            r_h_seg   <= w_h_seg_nxt;
            r_v_seg   <= w_v_seg_nxt;
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            if (w_h_wrap && w_v_wrap) r_frame_cnt <= r_frame_cnt + FCW'(1);
        end
    end

    // request stage: register the current position and its phase-derived flags
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_live  <= 1'b0;
            r_req_valid <= 1'b0;
            r_req_hsync <= ~H_POL;
            r_req_vsync <= ~V_POL;
            r_req_x     <= '0;
            r_req_y     <= '0;
        end else if (en) begin
            r_req_live  <= 1'b1;
            r_req_valid <= (r_h_phase == ACTIVE) && (r_v_phase == ACTIVE);
            r_req_hsync <= (r_h_phase == SYNC) ? H_POL : ~H_POL;
            r_req_vsync <= (r_v_phase == SYNC) ? V_POL : ~V_POL;
            r_req_x     <= r_h;
            r_req_y     <= r_v;
        end
    end

    // live marks a real position so the idle (0,0) after reset never decodes as a strobe
    assign w_req_bus = {r_req_live, r_req_valid, r_req_hsync, r_req_vsync, r_req_x, r_req_y};

    vga_delay_line #(
        .W       (PW),
        .DEPTH   (LOOKAHEAD),
        .RST_VAL (PIPE_IDLE)
    ) u_disp_dly (
        .i_clk   (vgaclk),
        .i_rst_n (rst_n),
        .i_en    (en),
        .i_d     (w_req_bus),
        .o_q     (w_disp_bus)
    );

    assign {w_disp_live, vga_blank, hsync, vsync, counter_H, counter_V} = w_disp_bus;

    assign vga_sync    = hsync & vsync;
    assign line_start  = w_disp_live && (counter_H == '0);
    assign frame_start = w_disp_live && (counter_H == '0) && (counter_V == '0);
    assign req_valid   = r_req_valid;
    assign req_x       = r_req_x;
    assign req_y       = r_req_y;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against an
// arithmetic raster model indexed by the number of enabled cycles since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha, hf, hs, hb, va, vf, vs, vb, la, fcw, hpol, vpol;
    } cfg_t;

    typedef struct packed {
        int rv, rx, ry, bl, ch, cv, hs, vs, sy, fs, ls, fc;
    } exp_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 8, 0, 0};
    localparam cfg_t CFG_B = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 8, 0, 0};
    localparam cfg_t CFG_C = '{8, 2, 3, 2, 4, 1, 2, 1, 2, 2, 1, 1};

    logic clk = 1'b0;
    logic rst_ab = 1'b0, en_ab = 1'b1;
    logic rst_c  = 1'b0, en_c  = 1'b1;
    int   k_ab = 0, k_c = 0;
    int   n_pass = 0, n_checks = 0;

    logic        hs_a, vs_a, sy_a, bl_a, fs_a, ls_a, rv_a;
    logic [10:0] ch_a, cv_a, rx_a, ry_a;
    logic [7:0]  fc_a;
    logic        hs_b, vs_b, sy_b, bl_b, fs_b, ls_b, rv_b;
    logic [10:0] ch_b, cv_b, rx_b, ry_b;
    logic [7:0]  fc_b;
    logic        hs_c, vs_c, sy_c, bl_c, fs_c, ls_c, rv_c;
    logic [4:0]  ch_c, cv_c, rx_c, ry_c;
    logic [1:0]  fc_c;

    always #5 clk = ~clk;

    vga_timing_gen #(.LOOKAHEAD(2)) u_a (
        .vgaclk(clk), .rst_n(rst_ab), .en(en_ab),
        .hsync(hs_a), .vsync(vs_a), .vga_sync(sy_a), .vga_blank(bl_a),
        .counter_H(ch_a), .counter_V(cv_a), .frame_start(fs_a), .line_start(ls_a),
        .req_valid(rv_a), .req_x(rx_a), .req_y(ry_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(.LOOKAHEAD(0)) u_b (
        .vgaclk(clk), .rst_n(rst_ab), .en(en_ab),
        .hsync(hs_b), .vsync(vs_b), .vga_sync(sy_b), .vga_blank(bl_b),
        .counter_H(ch_b), .counter_V(cv_b), .frame_start(fs_b), .line_start(ls_b),
        .req_valid(rv_b), .req_x(rx_b), .req_y(ry_b), .frame_cnt(fc_b)
    );

    vga_timing_gen #(
        .CW(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .LOOKAHEAD(2), .FCW(2)
    ) u_c (
        .vgaclk(clk), .rst_n(rst_c), .en(en_c),
        .hsync(hs_c), .vsync(vs_c), .vga_sync(sy_c), .vga_blank(bl_c),
        .counter_H(ch_c), .counter_V(cv_c), .frame_start(fs_c), .line_start(ls_c),
        .req_valid(rv_c), .req_x(rx_c), .req_y(ry_c), .frame_cnt(fc_c)
    );

    // Expected outputs after k enabled cycles since reset release.
    function automatic exp_t model(input cfg_t c, input int k);
        exp_t m;
        int ht, vt, fr, idx, d, h, v;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        fr = ht * vt;
        m = '0;
        m.hs = (c.hpol == 0) ? 1 : 0;
        m.vs = (c.vpol == 0) ? 1 : 0;
        m.fc = (k / fr) % (1 << c.fcw);
        if (k > 0) begin
            idx  = (k - 1) % fr;
            m.rx = idx % ht;
            m.ry = idx / ht;
            m.rv = (m.rx < c.ha && m.ry < c.va) ? 1 : 0;
        end
        d = k - c.la;
        if (d > 0) begin
            idx  = (d - 1) % fr;
            h    = idx % ht;
            v    = idx / ht;
            m.ch = h;
            m.cv = v;
            m.bl = (h < c.ha && v < c.va) ? 1 : 0;
            m.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hpol : 1 - c.hpol;
            m.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vpol : 1 - c.vpol;
            m.ls = (h == 0) ? 1 : 0;
            m.fs = (h == 0 && v == 0) ? 1 : 0;
        end
        m.sy = m.hs & m.vs;
        return m;
    endfunction

    function automatic void chk(input string nm, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    endfunction

    function automatic void chk_inst(input string t, input cfg_t c, input int k,
                                     input int rv, input int rx, input int ry, input int bl,
                                     input int ch, input int cv, input int hs, input int vs,
                                     input int sy, input int fs, input int ls, input int fc);
        exp_t m;
        m = model(c, k);
        chk({t, ".req_valid"},   rv, m.rv);
        chk({t, ".req_x"},       rx, m.rx);
        chk({t, ".req_y"},       ry, m.ry);
        chk({t, ".vga_blank"},   bl, m.bl);
        chk({t, ".counter_H"},   ch, m.ch);
        chk({t, ".counter_V"},   cv, m.cv);
        chk({t, ".hsync"},       hs, m.hs);
        chk({t, ".vsync"},       vs, m.vs);
        chk({t, ".vga_sync"},    sy, m.sy);
        chk({t, ".frame_start"}, fs, m.fs);
        chk({t, ".line_start"},  ls, m.ls);
        chk({t, ".frame_cnt"},   fc, m.fc);
    endfunction

    // enabled-cycle counters that index the model
    always @(posedge clk) begin
        k_ab <= !rst_ab ? 0 : (en_ab ? k_ab + 1 : k_ab);
        k_c  <= !rst_c  ? 0 : (en_c  ? k_c + 1  : k_c);
    end

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk_inst("A", CFG_A, rst_ab ? k_ab : 0, int'(rv_a), int'(rx_a), int'(ry_a), int'(bl_a),
                 int'(ch_a), int'(cv_a), int'(hs_a), int'(vs_a), int'(sy_a), int'(fs_a),
                 int'(ls_a), int'(fc_a));
        chk_inst("B", CFG_B, rst_ab ? k_ab : 0, int'(rv_b), int'(rx_b), int'(ry_b), int'(bl_b),
                 int'(ch_b), int'(cv_b), int'(hs_b), int'(vs_b), int'(sy_b), int'(fs_b),
                 int'(ls_b), int'(fc_b));
        chk_inst("C", CFG_C, rst_c ? k_c : 0, int'(rv_c), int'(rx_c), int'(ry_c), int'(bl_c),
                 int'(ch_c), int'(cv_c), int'(hs_c), int'(vs_c), int'(sy_c), int'(fs_c),
                 int'(ls_c), int'(fc_c));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, cnt, first, nbl, last, period, hcnt, hfirst, vcnt, vfirst;

        // reset held
        repeat (3) step();
        chk("A.rst.counter_H", int'(ch_a), 0);
        chk("A.rst.vga_blank", int'(bl_a), 0);
        chk("A.rst.hsync", int'(hs_a), 1);
        chk("A.rst.vsync", int'(vs_a), 1);
        chk("A.rst.frame_start", int'(fs_a), 0);
        chk("A.rst.req_valid", int'(rv_a), 0);
        chk("C.rst.hsync", int'(hs_c), 0);
        chk("C.rst.vsync", int'(vs_c), 0);

        // release; first enabled edge shows (0,0) on the request side
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        step();
        chk("A.first.req_valid", int'(rv_a), 1);
        chk("A.first.req_x", int'(rx_a), 0);
        chk("A.first.vga_blank", int'(bl_a), 0);
        chk("B.first.vga_blank", int'(bl_b), 1);
        chk("B.first.frame_start", int'(fs_b), 1);
        step();
        chk("A.second.frame_start", int'(fs_a), 0);
        step();
        chk("A.la.counter_H", int'(ch_a), 0);
        chk("A.la.counter_V", int'(cv_a), 0);
        chk("A.la.vga_blank", int'(bl_a), 1);
        chk("A.la.frame_start", int'(fs_a), 1);
        chk("C.la.frame_start", int'(fs_c), 1);

        // one full line of A
        cnt = 0; first = -1; nbl = 0; last = -1;
        for (int i = 0; i < 800; i++) begin
            if (hs_a == 1'b0) begin
                cnt++;
                if (first < 0) first = int'(ch_a);
            end
            if (bl_a) begin
                nbl++;
                last = int'(ch_a);
            end
            step();
        end
        chk("A.hsync_low_cycles", cnt, 96);
        chk("A.hsync_first_h", first, 656);
        chk("A.blank_cycles", nbl, 640);
        chk("A.blank_last_h", last, 639);
        chk("A.next_line_start", int'(ls_a), 1);

        // freeze mid-line
        n = 0;
        while (ch_a != 11'd300 && n < 2000) begin step(); n++; end
        chk("A.reach_h300", int'(n < 2000), 1);
        en_ab = 1'b0;
        cnt = 0;
        repeat (37) begin
            step();
            if (ch_a == 11'd300 && rx_a == 11'd302) cnt++;
        end
        chk("A.frozen_cycles", cnt, 37);
        en_ab = 1'b1;
        step();
        chk("A.resume_counter_H", int'(ch_a), 301);

        // request (100,7): same cycle on B, two cycles later on A
        n = 0;
        while (!(rx_a == 11'd100 && ry_a == 11'd7) && n < 8000) begin step(); n++; end
        chk("A.reach_req_100_7", int'(n < 8000), 1);
        chk("B.same_cycle.counter_H", int'(ch_b), 100);
        chk("B.same_cycle.counter_V", int'(cv_b), 7);
        chk("B.same_cycle.vga_blank", int'(bl_b), 1);
        step();
        step();
        chk("A.la2.counter_H", int'(ch_a), 100);
        chk("A.la2.counter_V", int'(cv_a), 7);
        chk("A.la2.vga_blank", int'(bl_a), 1);

        // reduced config: frame counter wrap
        n = 0;
        while (fc_c != 2'd3 && n < 600) begin step(); n++; end
        chk("C.reach_frame_cnt3", int'(n < 600), 1);
        n = 0;
        while (fc_c == 2'd3 && n < 200) begin step(); n++; end
        chk("C.frame_cnt_wrap", int'(fc_c), 0);

        // reduced config: one whole frame from a frame_start
        n = 0;
        while (!fs_c && n < 300) begin step(); n++; end
        chk("C.reach_frame_start", int'(n < 300), 1);
        period = 0; hcnt = 0; hfirst = -1; vcnt = 0; vfirst = -1;
        for (int i = 0; i < 300; i++) begin
            if (cv_c == 5'd0 && hs_c) begin
                hcnt++;
                if (hfirst < 0) hfirst = int'(ch_c);
            end
            if (ch_c == 5'd0 && vs_c) begin
                vcnt++;
                if (vfirst < 0) vfirst = int'(cv_c);
            end
            step();
            period++;
            if (fs_c) break;
        end
        chk("C.frame_period", period, 120);
        chk("C.hsync_high_cycles", hcnt, 3);
        chk("C.hsync_first_h", hfirst, 10);
        chk("C.vsync_lines", vcnt, 2);
        chk("C.vsync_first_line", vfirst, 5);

        // reduced config: reset at (5,2)
        n = 0;
        while (!(ch_c == 5'd5 && cv_c == 5'd2) && n < 300) begin step(); n++; end
        chk("C.reach_5_2", int'(n < 300), 1);
        rst_c = 1'b0;
        #1;
        chk("C.midrst.counter_H", int'(ch_c), 0);
        chk("C.midrst.counter_V", int'(cv_c), 0);
        chk("C.midrst.hsync", int'(hs_c), 0);
        chk("C.midrst.vsync", int'(vs_c), 0);
        chk("C.midrst.frame_cnt", int'(fc_c), 0);
        chk("C.midrst.req_valid", int'(rv_c), 0);
        chk("C.midrst.vga_blank", int'(bl_c), 0);
        step();
        rst_c = 1'b1;

        // randomized enable and occasional resets
        for (int i = 0; i < 20000; i++) begin
            en_ab  = ($urandom_range(0, 9) != 0);
            en_c   = ($urandom_range(0, 7) != 0);
            rst_ab = ($urandom_range(0, 2999) != 0);
            rst_c  = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
